// File: rtl/nibble_sub_seq.sv
// nibble_sub_seq: sequential N-bit subtractor (A-B) working one nibble per clock; ports clk, rst_n (sync active-low), start, A, B in; busy, done, D, B_out (unsigned borrow), Ofl (signed overflow), Z (zero) out.
module nibble_sub_seq #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         B_out,
  output logic         Ofl,
  output logic         Z
);
  localparam int NN = N / 4;
  localparam int CW = NN > 1 ? $clog2(NN) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       state;
  logic [CW-1:0] cnt;
  logic         carry;
  logic [N-1:0] a_r, b_r, d_next;
  logic [4:0]   sum;
  logic         last;
  always_comb begin
    sum = {1'b0, a_r[4*cnt +: 4]} + {1'b0, ~b_r[4*cnt +: 4]} + {4'b0, carry};
    d_next = D;
    d_next[4*cnt +: 4] = sum[3:0];
    last = cnt == CW'(NN - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      B_out <= 1'b0;
      Ofl   <= 1'b0;
      Z     <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
    end else if (state == RUN) begin
      D     <= d_next;
      carry <= sum[4];
      cnt   <= cnt + 1'b1;
      if (last) begin
        B_out <= ~sum[4];
        Ofl   <= (a_r[N-1] != b_r[N-1]) && (sum[3] != a_r[N-1]);
        Z     <= d_next == '0;
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end else if (start) begin
      a_r   <= A;
      b_r   <= B;
      D     <= '0;
      B_out <= 1'b0;
      Ofl   <= 1'b0;
      Z     <= 1'b0;
      cnt   <= '0;
      carry <= 1'b1;
      state <= RUN;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
endmodule

// File: doc/nibble_sub_seq.md
NIBBLE_SUB_SEQ -- requirements
Module: nibble_sub_seq

Interface
REQ-001 SHALL have parameter N, default 16, the operand/result width in bits; legal values are multiples of 4 from 4 to 32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction, sampled on the rising edge.
REQ-005 SHALL have port A, input, N, minuend, sampled only on an accepted start.
REQ-006 SHALL have port B, input, N, subtrahend, sampled only on an accepted start.
REQ-007 SHALL have port busy, output, 1, high while a subtraction is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking D and the flags valid.
REQ-009 SHALL have port D, output, N, difference A-B.
REQ-010 SHALL have port B_out, output, 1, unsigned borrow: 1 when A<B unsigned.
REQ-011 SHALL have port Ofl, output, 1, signed two's-complement overflow.
REQ-012 SHALL have port Z, output, 1, high when D==0.

Function
REQ-013 SHALL implement three states, IDLE, RUN and DONE, a nibble counter cnt of width clog2(N/4) (at least 1 bit), and a 1-bit carry register.
REQ-014 In IDLE or DONE with start=1 at edge k: capture A and B; clear D, B_out, Ofl and Z to 0; set cnt=0 and carry=1; enter RUN.
REQ-015 In RUN at each edge: compute nibble sum = A[cnt] + ~B[cnt] + carry (4 bits plus carry out); write it into D[4*cnt+3:4*cnt]; store the carry out; increment cnt.
REQ-016 At the RUN edge where cnt==N/4-1: set B_out = ~carry_out, Ofl = (A[N-1]!=B[N-1]) && (D_final[N-1]!=A[N-1]), and Z = (D_final==0); enter DONE.
REQ-017 Latency: done=1 during exactly the cycle following edge k+N/4 (k+4 for N=16); D and the flags are valid from then until the next accepted start.
REQ-018 busy SHALL be 1 exactly while the state is RUN; done SHALL be 1 exactly while the state is DONE.
REQ-019 In DONE without start, the block SHALL return to IDLE at the next edge; D and the flags hold their values.
REQ-020 start while in RUN SHALL be ignored: no operand recapture and no change to the sequence or latency.
REQ-021 start in DONE SHALL be accepted as in REQ-014 (back-to-back operation); done is still a one-cycle pulse.
REQ-022 A and B changing after capture SHALL NOT affect the result.
REQ-023 Wrap-around: D is modulo 2^N; the carry beyond bit N-1 appears only through B_out.
REQ-024 During RUN, D holds partial results; consumers SHALL qualify D with done or with IDLE following done.

Reset
REQ-025 While rst_n=0 at an edge: state=IDLE, cnt=0, carry=0, busy=0, done=0, D=0, B_out=0, Ofl=0, Z=0; captured operands are cleared to 0.
REQ-026 Reset SHALL take priority over start and abort an in-progress RUN with no done pulse.
REQ-027 After reset is released, the first start SHALL behave exactly as in REQ-014.

Verification (N=16)
REQ-028 A=0x1234, B=0x0234, start pulse -> busy for 4 cycles, then done with D=0x1000, B_out=0, Ofl=0, Z=0.
REQ-029 A=0x0000, B=0x0001 -> D=0xFFFF, B_out=1, Ofl=0, Z=0; A=0x8000, B=0x0001 -> D=0x7FFF, B_out=0, Ofl=1, Z=0.
REQ-030 A=0x5A5A, B=0x5A5A -> D=0x0000, Z=1, B_out=0, Ofl=0; A=0x7FFF, B=0xFFFF -> D=0x8000, B_out=1, Ofl=1.
REQ-031 start held high continuously from A=0x0010, B=0x0001 -> the start pulses in RUN are ignored; done with D=0x000F; the start seen during the done cycle launches the next operation immediately with no IDLE cycle.
REQ-032 rst_n=0 for one cycle at the second RUN cycle -> no done pulse; all outputs 0 next cycle; a new start with A=0x0003, B=0x0005 gives D=0xFFFE, B_out=1.
REQ-033 A and B changed every cycle during RUN -> the result matches the operands captured at start.
